fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one fetch request at a time
// to instruction memory, registers the returned word and presents it to the
// control unit until the downstream stage releases it.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] PC
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc_sum;
  logic [ADDR_WIDTH-1:0] pc_next;

  // Branch target or sequential address; wraps naturally, word-aligned.
  always_comb begin
    pc_sum  = PCsrc ? (PC + ImmOp) : (PC + ADDR_WIDTH'(4));
    pc_next = {pc_sum[ADDR_WIDTH-1:2], 2'b00};
  end

  // Outputs decode directly from the state register, never from inputs.
  always_comb begin
    imem_req    = (state == REQ);
    instr_valid = (state == HOLD);
    imem_addr   = PC;
  end

  // Fetch sequencing: IDLE -> REQ, wait for ack, then HOLD until released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      PC    <= RESET_PC;
      instr <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            PC    <= pc_next;
            state <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an address/instruction scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;

  logic [31:0] salt = 32'h0;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PC         (PC)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory model: the word at an address is a scrambled function of it.
  assign imem_rdata = (imem_addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ salt;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ salt;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectAddr(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic expectInstr(input logic [31:0] a);
    instr_q.push_back(memWord(a));
  endtask

  // From a stalled HOLD: release with the given branch inputs, then
  // re-stall during REQ (must be ignored) and land in HOLD at exp_pc.
  task automatic applyStimulus(input logic pcsrc, input logic [31:0] imm,
                               input logic [31:0] exp_pc);
    PCsrc = pcsrc;
    ImmOp = imm;
    stall = 1'b0;
    expectAddr(exp_pc);
    expectInstr(exp_pc);
    cycle();
    checkOutput("req_in_REQ", {31'd0, imem_req}, 32'd1);
    checkOutput("pc_in_REQ", PC, exp_pc);
    checkOutput("valid_in_REQ", {31'd0, instr_valid}, 32'd0);
    stall = 1'b1;
    PCsrc = ~pcsrc;
    ImmOp = $urandom;
    cycle();
    checkOutput("valid_in_HOLD", {31'd0, instr_valid}, 32'd1);
    checkOutput("pc_in_HOLD", PC, exp_pc);
  endtask

  // Scoreboard: each new request and each newly valid word is checked
  // against the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (imem_req === 1'b1 && prev_req !== 1'b1) begin
      exp = (addr_q.size() > 0) ? addr_q.pop_front() : ~imem_addr;
      checkOutput("fetch_addr", imem_addr, exp);
    end
    if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      exp = (instr_q.size() > 0) ? instr_q.pop_front() : ~instr;
      checkOutput("fetch_instr", instr, exp);
    end
    prev_req   <= imem_req;
    prev_valid <= instr_valid;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst      = 1'b1;
    PCsrc    = 1'b0;
    ImmOp    = 32'h0;
    stall    = 1'b0;
    imem_ack = 1'b0;

    // Reset state, then back-to-back fetches with immediate ack.
    cycle();
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_pc", PC, 32'h0);
    rst      = 1'b0;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expectAddr(32'(i * 4));
      expectInstr(32'(i * 4));
    end
    cycle();
    checkOutput("first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("first_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      cycle();
      checkOutput("toggle_valid", {31'd0, instr_valid}, 32'(k % 2));
      checkOutput("toggle_req", {31'd0, imem_req}, 32'((k + 1) % 2));
    end
    stall = 1'b1;

    // Stall in HOLD with PCsrc toggling; nothing may move.
    for (int k = 0; k < 5; k++) begin
      PCsrc = k[0];
      ImmOp = 32'h100;
      cycle();
      checkOutput("stall_pc", PC, 32'hC);
      checkOutput("stall_instr", instr, memWord(32'hC));
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    applyStimulus(1'b0, 32'h100, 32'h10);

    // Branches: negative offset, forward offset, low bits cleared, wrap.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 32'h08);
    applyStimulus(1'b1, 32'h8, 32'h10);
    applyStimulus(1'b1, 32'h6, 32'h14);
    applyStimulus(1'b1, 32'hFFFF_FFE8, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 32'h0);

    // Delayed ack after reset: request held while memory is slow.
    rst      = 1'b1;
    imem_ack = 1'b0;
    cycle();
    checkOutput("rst2_instr", instr, 32'h0);
    checkOutput("rst2_valid", {31'd0, instr_valid}, 32'd0);
    rst  = 1'b0;
    salt = 32'h1234_5678;
    expectAddr(32'h0);
    expectInstr(32'h0);
    cycle();
    checkOutput("slow_req0", {31'd0, imem_req}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("slow_req", {31'd0, imem_req}, 32'd1);
      checkOutput("slow_pc", PC, 32'h0);
      checkOutput("slow_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    cycle();
    checkOutput("slow_done_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("slow_done_req", {31'd0, imem_req}, 32'd0);

    // Reset during REQ with ack in the same cycle, then a late ack in IDLE.
    imem_ack = 1'b0;
    stall    = 1'b0;
    PCsrc    = 1'b0;
    expectAddr(32'h4);
    cycle();
    checkOutput("abort_req", {31'd0, imem_req}, 32'd1);
    checkOutput("abort_pc", PC, 32'h4);
    rst      = 1'b1;
    imem_ack = 1'b1;
    stall    = 1'b1;
    cycle();
    checkOutput("abort_instr", instr, 32'h0);
    checkOutput("abort_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("abort_idle_req", {31'd0, imem_req}, 32'd0);
    checkOutput("abort_pc_reset", PC, 32'h0);
    rst  = 1'b0;
    salt = 32'hCAFE_F00D;
    expectAddr(32'h0);
    cycle();
    checkOutput("late_ack_instr", instr, 32'h0);
    checkOutput("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("late_ack_req", {31'd0, imem_req}, 32'd1);
    expectInstr(32'h0);
    cycle();
    checkOutput("refetch_valid", {31'd0, instr_valid}, 32'd1);

    @(negedge clk);
    #1;
    checkOutput("addr_q_drained", 32'(addr_q.size()), 32'd0);
    checkOutput("instr_q_drained", 32'(instr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
